// File: rtl/int_dp_controller.sv
// Multi-cycle controller for the 32-bit integer datapath: accepts one MIPS word per
// handshake, decodes it and sequences register file, ALU, HI/LO and Y-mux controls.
module int_dp_controller #(
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_valid,
  input  logic [31:0] ir,
  output logic        ir_ready,
  input  logic        V,
  output logic [4:0]  S_Addr,
  output logic [4:0]  T_Addr,
  output logic [4:0]  D_Addr,
  output logic        D_En,
  output logic [4:0]  FS,
  output logic        T_Sel,
  output logic [31:0] DT,
  output logic [2:0]  Y_Sel,
  output logic        HILO_ld,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        ovf
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ILL} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             wr_q, hilo_q, chkv_q, bad_q;
  logic             accept, den_nx, hilo_nx, done_nx, ill_nx, ovf_nx;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        dec_bad, dec_wr, dec_hilo, dec_chkv, dec_tsel;
  logic [4:0]  dec_fs, dec_da;
  logic [31:0] dec_dt;
  logic [2:0]  dec_ysel;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  // Decode straight from the incoming word so the controls are valid in the DECODE cycle
  always_comb begin
    dec_bad  = 1'b0;
    dec_wr   = 1'b0;
    dec_hilo = 1'b0;
    dec_chkv = 1'b0;
    dec_fs   = 5'h00;
    dec_da   = rd;
    dec_tsel = 1'b0;
    dec_dt   = 32'h0;
    dec_ysel = 3'd2;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_fs = 5'h02; dec_wr = 1'b1; dec_chkv = 1'b1; end
          6'h22: begin dec_fs = 5'h04; dec_wr = 1'b1; dec_chkv = 1'b1; end
          6'h24: begin dec_fs = 5'h08; dec_wr = 1'b1; end
          6'h25: begin dec_fs = 5'h09; dec_wr = 1'b1; end
          6'h26: begin dec_fs = 5'h0A; dec_wr = 1'b1; end
          6'h27: begin dec_fs = 5'h0B; dec_wr = 1'b1; end
          6'h2A: begin dec_fs = 5'h06; dec_wr = 1'b1; end
          6'h18: begin dec_fs = 5'h1E; dec_hilo = 1'b1; dec_da = 5'd0; dec_ysel = 3'd0; end
          6'h1A: begin dec_fs = 5'h1F; dec_hilo = 1'b1; dec_da = 5'd0; dec_ysel = 3'd0; end
          6'h10: begin dec_ysel = 3'd4; dec_wr = 1'b1; end
          6'h12: begin dec_ysel = 3'd3; dec_wr = 1'b1; end
          default: dec_bad = 1'b1;
        endcase
      end
      6'h08: begin
        dec_fs = 5'h02; dec_tsel = 1'b1; dec_dt = {{16{imm[15]}}, imm};
        dec_da = rt; dec_wr = 1'b1; dec_chkv = 1'b1;
      end
      6'h0A: begin dec_fs = 5'h06; dec_tsel = 1'b1; dec_dt = {{16{imm[15]}}, imm}; dec_da = rt; dec_wr = 1'b1; end
      6'h0C: begin dec_fs = 5'h08; dec_tsel = 1'b1; dec_dt = {16'h0, imm}; dec_da = rt; dec_wr = 1'b1; end
      6'h0D: begin dec_fs = 5'h09; dec_tsel = 1'b1; dec_dt = {16'h0, imm}; dec_da = rt; dec_wr = 1'b1; end
      6'h0E: begin dec_fs = 5'h0A; dec_tsel = 1'b1; dec_dt = {16'h0, imm}; dec_da = rt; dec_wr = 1'b1; end
      default: dec_bad = 1'b1;
    endcase
  end

  // Next state plus next values of the registered pulse outputs
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    den_nx   = 1'b0;
    done_nx  = 1'b0;
    ovf_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (ir_valid && ir_ready) begin
          state_nx = DECODE;
          accept   = 1'b1;
        end
      end
      DECODE: begin
        cnt_nx   = '0;
        state_nx = bad_q ? ILL : EXEC;
      end
      EXEC: begin
        if (hilo_q && (cnt != CNT_LAST)) begin
          cnt_nx = cnt + 1'b1;
        end else begin
          state_nx = WB;
          den_nx   = wr_q && (D_Addr != 5'd0) && !(chkv_q && V);
          ovf_nx   = chkv_q && V;
          done_nx  = 1'b1;
        end
      end
      WB:      state_nx = IDLE;
      ILL:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    hilo_nx = (state_nx == EXEC) && hilo_q && (cnt_nx == CNT_LAST);
    ill_nx  = (state_nx == ILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ir_ready <= 1'b1;
      busy     <= 1'b0;
      D_En     <= 1'b0;
      HILO_ld  <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      ovf      <= 1'b0;
      S_Addr   <= 5'd0;
      T_Addr   <= 5'd0;
      D_Addr   <= 5'd0;
      FS       <= 5'd0;
      T_Sel    <= 1'b0;
      DT       <= 32'h0;
      Y_Sel    <= 3'd0;
      wr_q     <= 1'b0;
      hilo_q   <= 1'b0;
      chkv_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ir_ready <= (state_nx == IDLE);
      busy     <= (state_nx != IDLE);
      D_En     <= den_nx;
      HILO_ld  <= hilo_nx;
      done     <= done_nx;
      illegal  <= ill_nx;
      ovf      <= ovf_nx;
      if (accept) begin
        S_Addr <= rs;
        T_Addr <= rt;
        D_Addr <= dec_da;
        FS     <= dec_fs;
        T_Sel  <= dec_tsel;
        DT     <= dec_dt;
        Y_Sel  <= dec_ysel;
        wr_q   <= dec_wr;
        hilo_q <= dec_hilo;
        chkv_q <= dec_chkv;
        bad_q  <= dec_bad;
      end
    end
  end

endmodule

// File: tb/tb_int_dp_controller.sv
// Scoreboard bench for int_dp_controller: issued instructions queue their expected
// retirement; a monitor pops and compares on every done/illegal pulse.
module tb_int_dp_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ir_valid = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        ir_ready;
  logic        V = 1'b0;
  logic [4:0]  S_Addr, T_Addr, D_Addr, FS;
  logic        D_En, T_Sel, HILO_ld, busy, done, illegal, ovf;
  logic [31:0] DT;
  logic [2:0]  Y_Sel;

  int_dp_controller #(.DIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir(ir), .ir_ready(ir_ready),
    .V(V), .S_Addr(S_Addr), .T_Addr(T_Addr), .D_Addr(D_Addr), .D_En(D_En),
    .FS(FS), .T_Sel(T_Sel), .DT(DT), .Y_Sel(Y_Sel), .HILO_ld(HILO_ld),
    .busy(busy), .done(done), .illegal(illegal), .ovf(ovf)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -1 in any field means "not checked"
  typedef struct {
    longint acc, ill, lat, hilo, den, da, ov, s, t, fs, ts, dt, ys;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     hilo_cnt = 0;
  longint hilo_cyc = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    if (expv < 0) return;
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t ex(input longint ill, lat, hilo, den, da, ov,
                              s, t, fs, ts, dt, ys);
    exp_t e;
    e.acc = 0; e.ill = ill; e.lat = lat; e.hilo = hilo; e.den = den; e.da = da;
    e.ov = ov; e.s = s; e.t = t; e.fs = fs; e.ts = ts; e.dt = dt; e.ys = ys;
    return e;
  endfunction

  task automatic issue(input logic [31:0] w, input exp_t e, input bit push);
    int n = 0;
    @(negedge clk);
    ir = w;
    ir_valid = 1'b1;
    while (!ir_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir_ready) begin
      errors++;
      $display("FAIL accept_timeout: ir_ready low for %0d cycles, word 0x%08h", n, w);
      ir_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.acc = cyc;
    #1 ir_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still pending", exp_q.size());
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (HILO_ld) begin
          hilo_cnt++;
          hilo_cyc = cyc;
        end
        if (D_En && HILO_ld) begin
          errors++;
          $display("FAIL den_hilo_overlap: D_En=1 HILO_ld=1 required not both (cycle %0d)", cyc);
        end
        if (D_En && !done) begin
          errors++;
          $display("FAIL den_outside_wb: D_En=1 done=0 required D_En only in WB (cycle %0d)", cyc);
        end
        if (done || illegal) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_retire: done=%0b illegal=%0b with nothing issued (cycle %0d)",
                     done, illegal, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc - e.acc, e.lat);
            chk("done", done, e.ill == 0 ? 1 : 0);
            chk("illegal", illegal, e.ill);
            chk("D_En", D_En, e.den);
            chk("ovf", ovf, e.ov);
            chk("hilo_pulses", hilo_cnt, e.hilo);
            if (e.hilo == 1) chk("hilo_cycle", hilo_cyc - e.acc, e.lat - 1);
            chk("D_Addr", D_Addr, e.da);
            chk("S_Addr", S_Addr, e.s);
            chk("T_Addr", T_Addr, e.t);
            chk("FS", FS, e.fs);
            chk("T_Sel", T_Sel, e.ts);
            chk("DT", DT, e.dt);
            chk("Y_Sel", Y_Sel, e.ys);
          end
          hilo_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ir_ready", ir_ready, 1);
    chk("rst_outputs", {S_Addr, T_Addr, D_Addr, D_En, FS, T_Sel, DT, Y_Sel,
                        HILO_ld, busy, done, illegal, ovf}, 0);
    reset = 1'b1;

    // ADD $3,$1,$2 with cycle-by-cycle checks
    issue(32'h00221820, ex(0,3,0,1,3,0,1,2,2,0,-1,2), 1);
    @(negedge clk);
    chk("add_c1_S", S_Addr, 1);
    chk("add_c1_T", T_Addr, 2);
    chk("add_c1_FS", FS, 2);
    chk("add_c1_Y", Y_Sel, 2);
    chk("add_c1_ready", ir_ready, 0);
    chk("add_c1_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("add_c4_ready", ir_ready, 1);

    // Back-to-back ALU and immediate forms
    issue(32'h2005FFFF, ex(0,3,0,1,5,0,0,5,2,1,'hFFFFFFFF,2), 1);   // ADDI $5,$0,-1
    issue(32'h3405FFFF, ex(0,3,0,1,5,0,0,5,9,1,'h0000FFFF,2), 1);   // ORI  $5,$0,0xFFFF
    issue(32'h39AC8001, ex(0,3,0,1,12,0,13,12,'hA,1,'h00008001,2), 1); // XORI $12,$13,0x8001
    issue(32'h28628000, ex(0,3,0,1,2,0,3,2,6,1,'hFFFF8000,2), 1);   // SLTI $2,$3,0x8000
    issue(32'h012A4022, ex(0,3,0,1,8,0,9,10,4,0,-1,2), 1);          // SUB  $8,$9,$10

    // HI/LO class then moves from HI/LO
    issue(32'h0086001A, ex(0,6,1,0,-1,0,4,6,'h1F,-1,-1,-1), 1);     // DIV  $4,$6
    issue(32'h00003812, ex(0,3,0,1,7,0,0,0,-1,-1,-1,3), 1);         // MFLO $7
    issue(32'h00220018, ex(0,6,1,0,-1,0,1,2,'h1E,-1,-1,-1), 1);     // MULT $1,$2
    issue(32'h00004810, ex(0,3,0,1,9,0,0,0,-1,-1,-1,4), 1);         // MFHI $9
    drain();

    // Overflow handling
    V = 1'b1;
    issue(32'h00221820, ex(0,3,0,0,3,1,1,2,2,0,-1,2), 1);           // ADD, V=1
    issue(32'h2005FFFF, ex(0,3,0,0,5,1,0,5,2,1,'hFFFFFFFF,2), 1);   // ADDI, V=1
    issue(32'h00221824, ex(0,3,0,1,3,0,1,2,8,0,-1,2), 1);           // AND ignores V
    drain();
    V = 1'b0;
    issue(32'h00220020, ex(0,3,0,0,0,0,1,2,2,0,-1,2), 1);           // ADD $0: no write

    // Illegal encodings, with ir_valid pulsing while busy
    issue(32'hFC000000, ex(1,2,0,0,-1,0,-1,-1,-1,-1,-1,-1), 1);
    @(negedge clk);
    ir = 32'h00221820;
    ir_valid = 1'b1;
    @(negedge clk);
    ir_valid = 1'b0;
    chk("ill_c2_ready", ir_ready, 0);
    @(negedge clk);
    chk("ill_c3_ready", ir_ready, 1);
    chk("ill_c3_busy", busy, 0);
    issue(32'h00000001, ex(1,2,0,0,-1,0,-1,-1,-1,-1,-1,-1), 1);     // bad funct
    drain();

    // Reset during the first EXEC cycle of a DIV
    issue(32'h0086001A, ex(0,6,1,0,-1,0,4,6,'h1F,-1,-1,-1), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_outputs", {S_Addr, T_Addr, D_Addr, D_En, FS, T_Sel, DT, Y_Sel,
                           HILO_ld, busy, done, illegal, ovf}, 0);
    chk("midrst_ready", ir_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_ready", ir_ready, 1);
    chk("postrst_busy", busy, 0);
    repeat (6) @(negedge clk);
    chk("postrst_no_hilo", hilo_cnt, 0);

    // Controller still works after the abort
    issue(32'h00221820, ex(0,3,0,1,3,0,1,2,2,0,-1,2), 1);
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
